// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D memory arbiter.
// Struct widths match the arbiter's default ADDR_W/DATA_W; the top casts at the boundary.
package mem_arb_pkg;

    localparam int WORD_OFS_W = 2;
    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_sel_t;

    typedef struct packed {
        logic                  we;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic                  rvalid;
        logic                  err;
        logic [ARB_DATA_W-1:0] rdata;
    } mem_rsp_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; bit 0 is the I requester, bit 1 the D requester.
// Grants are combinational and held off entirely while reset is asserted.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    gnt_sel_t   last_q;
    gnt_sel_t   last_d;
    logic [1:0] req_v;

    assign req_v = req_i & {2{reset_n}};

    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        case (req_v)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_q == GNT_D) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
        if (gnt_o[0]) begin
            last_d = GNT_I;
        end else if (gnt_o[1]) begin
            last_d = GNT_D;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_q <= GNT_D;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port word RAM between instruction fetch (I) and load/store (D),
// returning registered read data one cycle after grant and flagging bad addresses.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RAM_WORDS = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_enab,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] WORD_LIMIT = ADDR_W'(RAM_WORDS);

    logic [1:0]        gnt;
    mem_req_t          win;
    logic [ADDR_W-1:0] win_addr;
    logic              err_t;
    mem_rsp_t          i_rsp_q;
    mem_rsp_t          i_rsp_d;
    mem_rsp_t          d_rsp_q;
    mem_rsp_t          d_rsp_d;

    rr_arb2 u_arb (
        .clk    (clk),
        .reset_n(reset_n),
        .req_i  ({d_req, i_req}),
        .gnt_o  (gnt)
    );

    assign i_gnt = gnt[0];
    assign d_gnt = gnt[1];

    // Everything driven to the RAM is zero unless its owner holds the grant.
    always_comb begin
        win = '0;
        if (i_gnt) begin
            win.addr = ARB_ADDR_W'(i_addr);
        end else if (d_gnt) begin
            win.we    = d_we;
            win.addr  = ARB_ADDR_W'(d_addr);
            win.wdata = ARB_DATA_W'(d_wdata);
        end
    end

    assign win_addr  = ADDR_W'(win.addr);
    assign err_t     = (win_addr[WORD_OFS_W-1:0] != '0) |
                       ((win_addr >> WORD_OFS_W) >= WORD_LIMIT);
    assign mem_addr  = win_addr;
    assign mem_wdata = DATA_W'(win.wdata);
    assign mem_enab  = win.we & ~err_t;

    // rdata is loaded only on grant, so a write returns the pre-write word.
    always_comb begin
        i_rsp_d        = i_rsp_q;
        i_rsp_d.rvalid = i_gnt;
        i_rsp_d.err    = i_gnt & err_t;
        if (i_gnt) begin
            i_rsp_d.rdata = err_t ? '0 : ARB_DATA_W'(mem_rdata);
        end

        d_rsp_d        = d_rsp_q;
        d_rsp_d.rvalid = d_gnt;
        d_rsp_d.err    = d_gnt & err_t;
        if (d_gnt) begin
            d_rsp_d.rdata = err_t ? '0 : ARB_DATA_W'(mem_rdata);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            i_rsp_q <= '0;
            d_rsp_q <= '0;
        end else begin
            i_rsp_q <= i_rsp_d;
            d_rsp_q <= d_rsp_d;
        end
    end

    assign i_rvalid = i_rsp_q.rvalid;
    assign i_err    = i_rsp_q.err;
    assign i_rdata  = DATA_W'(i_rsp_q.rdata);
    assign d_rvalid = d_rsp_q.rvalid;
    assign d_err    = d_rsp_q.err;
    assign d_rdata  = DATA_W'(d_rsp_q.rdata);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, reset-mid-operation sequence,
// then randomized traffic checked against a transaction-level model.
module tb_mem_arbiter;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int RAM_WORDS = 64;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              i_req, i_gnt, i_rvalid, i_err;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata, d_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_enab;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_WORDS(RAM_WORDS)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_rdata  (i_rdata),
        .i_err    (i_err),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .mem_addr (mem_addr),
        .mem_enab (mem_enab),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM attached to the DUT; out-of-range reads return junk so error zeroing is visible.
    logic [DATA_W-1:0] ram [0:RAM_WORDS-1];
    assign mem_rdata = ((mem_addr >> 2) < RAM_WORDS) ? ram[mem_addr[7:2]] : 32'hBAD0_BAD0;
    always @(posedge clk) begin
        if (mem_enab && ((mem_addr >> 2) < RAM_WORDS)) ram[mem_addr[7:2]] <= mem_wdata;
    end

    // Reference model state: memory image, who won last, responses owed next cycle.
    logic [DATA_W-1:0] mmem [0:RAM_WORDS-1];
    bit                last_was_d;
    bit                p_iv, p_ie, p_dv, p_de;
    logic [DATA_W-1:0] p_id, p_dd;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit rst, input bit ir, input logic [31:0] ia,
                         input bit dr, input bit dwe, input logic [31:0] da,
                         input logic [31:0] dwd);
        reset_n = rst;
        i_req   = ir;
        i_addr  = ia;
        d_req   = dr;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dwd;
    endtask

    // Called at the negedge: predicts this cycle from the arbitration rules, then advances.
    task automatic model_cycle(input bit do_chk, output bit eig, output bit edg);
        logic [31:0] a;
        logic [31:0] wd;
        bit          err, enab;
        int          w;
        eig  = reset_n && i_req && (!d_req || last_was_d);
        edg  = reset_n && d_req && !eig;
        a    = eig ? i_addr : (edg ? d_addr : 32'h0);
        w    = int'(a >> 2);
        err  = (a[1:0] != 2'b00) || (w >= RAM_WORDS);
        enab = edg && d_we && !err;
        wd   = edg ? d_wdata : 32'h0;
        if (do_chk) begin
            chk("m_i_gnt", i_gnt, eig);
            chk("m_d_gnt", d_gnt, edg);
            chk("m_mem_addr", mem_addr, a);
            chk("m_mem_enab", mem_enab, enab);
            chk("m_mem_wdata", mem_wdata, wd);
            chk("m_i_rvalid", i_rvalid, p_iv);
            chk("m_d_rvalid", d_rvalid, p_dv);
            chk("m_i_err", i_err, p_iv && p_ie);
            chk("m_d_err", d_err, p_dv && p_de);
            if (p_iv) chk("m_i_rdata", i_rdata, p_id);
            if (p_dv) chk("m_d_rdata", d_rdata, p_dd);
        end
        if (!reset_n) begin
            {p_iv, p_ie, p_dv, p_de} = '0;
            last_was_d = 1'b1;
        end else begin
            p_iv = eig;
            p_ie = err;
            p_dv = edg;
            p_de = err;
            if (eig) p_id = err ? 32'h0 : mmem[w];
            if (edg) p_dd = err ? 32'h0 : mmem[w];
            if (enab) mmem[w] = d_wdata;
            if (eig) last_was_d = 1'b0;
            else if (edg) last_was_d = 1'b1;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 15);
        if (r == 0) return {$urandom_range(0, 63), 2'(1 + $urandom_range(0, 2))} & 32'hFF;
        if (r == 1) return 32'h100 + 4 * $urandom_range(0, 7);
        return 4 * $urandom_range(0, RAM_WORDS - 1);
    endfunction

    typedef struct {
        bit          rst, ir;
        logic [31:0] ia;
        bit          dr, dwe;
        logic [31:0] da, dwd;
        bit          eig, edg, een;
        logic [31:0] ema;
        bit          eiv, eie;
        logic [31:0] eid;
        bit          edv, ede;
        logic [31:0] edd;
    } vec_t;

    function automatic vec_t mk(bit rst, bit ir, logic [31:0] ia, bit dr, bit dwe,
                                logic [31:0] da, logic [31:0] dwd, bit eig, bit edg,
                                bit een, logic [31:0] ema, bit eiv, bit eie,
                                logic [31:0] eid, bit edv, bit ede, logic [31:0] edd);
        vec_t v;
        v = '{rst, ir, ia, dr, dwe, da, dwd, eig, edg, een, ema, eiv, eie, eid, edv, ede, edd};
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        bit          g_i, g_d;
        bit          i_hold, d_hold;
        bit          ir, dr, dwe, rst;
        logic [31:0] ia, da, dwd;

        for (int k = 0; k < RAM_WORDS; k++) begin
            ram[k]  = 32'h1000_0000 + 32'(k);
            mmem[k] = 32'h1000_0000 + 32'(k);
        end
        ram[5]     = 32'h0;
        mmem[5]    = 32'h0;
        last_was_d = 1'b1;
        {p_iv, p_ie, p_dv, p_de} = '0;
        p_id = '0;
        p_dd = '0;

        //          rst ir ia       dr we da       dwd           ig dg en ema      iv ie id            dv de dd
        tbl.push_back(mk(0, 1, 32'h0,   1, 0, 32'h4,  32'h0,        0, 0, 0, 32'h0,   0, 0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h0,   1, 0, 32'h4,  32'h0,        0, 0, 0, 32'h0,   0, 0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h0,   1, 0, 32'h4,  32'h0,        0, 0, 0, 32'h0,   0, 0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 32'h0,   1, 0, 32'h4,  32'h0,        1, 0, 0, 32'h0,   0, 0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h0,   1, 0, 32'h4,  32'h0,        0, 1, 0, 32'h4,   1, 0, 32'h10000000, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h0,   1, 1, 32'h14, 32'hDEADBEEF, 0, 1, 1, 32'h14,  0, 0, 32'h0,        1, 0, 32'h10000001));
        tbl.push_back(mk(1, 0, 32'h0,   1, 0, 32'h14, 32'h0,        0, 1, 0, 32'h14,  0, 0, 32'h0,        1, 0, 32'h0));
        tbl.push_back(mk(1, 1, 32'h8,   1, 0, 32'hC,  32'h0,        1, 0, 0, 32'h8,   0, 0, 32'h0,        1, 0, 32'hDEADBEEF));
        tbl.push_back(mk(1, 1, 32'h10,  1, 0, 32'hC,  32'h0,        0, 1, 0, 32'hC,   1, 0, 32'h10000002, 0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 32'h10,  1, 0, 32'h18, 32'h0,        1, 0, 0, 32'h10,  0, 0, 32'h0,        1, 0, 32'h10000003));
        tbl.push_back(mk(1, 1, 32'h20,  1, 0, 32'h18, 32'h0,        0, 1, 0, 32'h18,  1, 0, 32'h10000004, 0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 32'h20,  1, 0, 32'h1C, 32'h0,        1, 0, 0, 32'h20,  0, 0, 32'h0,        1, 0, 32'h10000006));
        tbl.push_back(mk(1, 1, 32'h24,  1, 0, 32'h1C, 32'h0,        0, 1, 0, 32'h1C,  1, 0, 32'h10000008, 0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 32'h24,  1, 1, 32'h15, 32'h1,        1, 0, 0, 32'h24,  0, 0, 32'h0,        1, 0, 32'h10000007));
        tbl.push_back(mk(1, 0, 32'h0,   1, 1, 32'h15, 32'h1,        0, 1, 0, 32'h15,  1, 0, 32'h10000009, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h0,   1, 0, 32'h14, 32'h0,        0, 1, 0, 32'h14,  0, 0, 32'h0,        1, 1, 32'h0));
        tbl.push_back(mk(1, 1, 32'h100, 0, 0, 32'h0,  32'h0,        1, 0, 0, 32'h100, 0, 0, 32'h0,        1, 0, 32'hDEADBEEF));
        tbl.push_back(mk(1, 1, 32'hFC,  0, 0, 32'h0,  32'h0,        1, 0, 0, 32'hFC,  1, 1, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0,   1, 0, 32'h1000003F, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h0,   0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0,   0, 0, 32'h0,        0, 0, 32'h0));

        foreach (tbl[r]) begin
            drive(tbl[r].rst, tbl[r].ir, tbl[r].ia, tbl[r].dr, tbl[r].dwe, tbl[r].da, tbl[r].dwd);
            @(negedge clk);
            chk($sformatf("v%0d_i_gnt", r), i_gnt, tbl[r].eig);
            chk($sformatf("v%0d_d_gnt", r), d_gnt, tbl[r].edg);
            chk($sformatf("v%0d_mem_enab", r), mem_enab, tbl[r].een);
            chk($sformatf("v%0d_mem_addr", r), mem_addr, tbl[r].ema);
            chk($sformatf("v%0d_i_rvalid", r), i_rvalid, tbl[r].eiv);
            chk($sformatf("v%0d_i_err", r), i_err, tbl[r].eie);
            chk($sformatf("v%0d_d_rvalid", r), d_rvalid, tbl[r].edv);
            chk($sformatf("v%0d_d_err", r), d_err, tbl[r].ede);
            if (tbl[r].eiv) chk($sformatf("v%0d_i_rdata", r), i_rdata, tbl[r].eid);
            if (tbl[r].edv) chk($sformatf("v%0d_d_rdata", r), d_rdata, tbl[r].edd);
            model_cycle(1'b0, g_i, g_d);
            @(posedge clk);
            #1;
        end

        // Reset in the cycle after an I grant: the response is dropped and D is last again.
        drive(1, 1, 32'h30, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rst_a_i_gnt", i_gnt, 1'b1);
        model_cycle(1'b0, g_i, g_d);
        @(posedge clk); #1;
        drive(0, 1, 32'h30, 1, 0, 32'h34, 32'h0);
        @(negedge clk);
        chk("rst_b_i_gnt", i_gnt, 1'b0);
        chk("rst_b_d_gnt", d_gnt, 1'b0);
        chk("rst_b_mem_enab", mem_enab, 1'b0);
        model_cycle(1'b0, g_i, g_d);
        @(posedge clk); #1;
        drive(1, 1, 32'h30, 1, 0, 32'h34, 32'h0);
        @(negedge clk);
        chk("rst_c_i_rvalid", i_rvalid, 1'b0);
        chk("rst_c_d_rvalid", d_rvalid, 1'b0);
        chk("rst_c_i_gnt", i_gnt, 1'b1);
        chk("rst_c_d_gnt", d_gnt, 1'b0);
        model_cycle(1'b0, g_i, g_d);
        @(posedge clk); #1;
        drive(1, 0, 32'h0, 1, 0, 32'h34, 32'h0);
        @(negedge clk);
        chk("rst_d_i_rvalid", i_rvalid, 1'b1);
        chk("rst_d_i_rdata", i_rdata, 32'h1000000C);
        chk("rst_d_d_gnt", d_gnt, 1'b1);
        model_cycle(1'b0, g_i, g_d);
        @(posedge clk); #1;

        // Random traffic; each requester holds its fields until the model says it was granted.
        i_hold = 1'b0;
        d_hold = 1'b0;
        ir = 1'b0; ia = '0; dr = 1'b0; dwe = 1'b0; da = '0; dwd = '0;
        for (int c = 0; c < 800; c++) begin
            if (!i_hold) begin
                ir     = ($urandom_range(0, 3) != 0);
                ia     = rand_addr();
                i_hold = ir;
            end
            if (!d_hold) begin
                dr     = ($urandom_range(0, 3) != 0);
                dwe    = $urandom_range(0, 1) == 1;
                da     = rand_addr();
                dwd    = $urandom;
                d_hold = dr;
            end
            rst = ($urandom_range(0, 63) != 0);
            drive(rst, ir, ia, dr, dwe, da, dwd);
            @(negedge clk);
            model_cycle(1'b1, g_i, g_d);
            if (g_i) i_hold = 1'b0;
            if (g_d) d_hold = 1'b0;
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
